store_narrow_unit: RTL and testbench

//  Multi-cycle sub-word store unit: the inverse of immediate/load extension. Takes a 32-bit

---
 rtl/store_narrow_unit_pkg.sv | 27 ++
 rtl/store_lane_merge.sv | 29 ++
 rtl/store_narrow_unit.sv | 109 ++++++++++
 tb/tb_store_narrow_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the store path.
//   SIZE_* : access size codes on SizeSel (also used by the load extender)
//   state_t: store FSM state encoding
//   isIllegal(): size/alignment check applied when a store is accepted
package store_narrow_unit_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  function automatic logic isIllegal(input logic [1:0] size, input logic [1:0] addrLo);
    return (size == SIZE_ILL)
        || ((size == SIZE_HALF) && addrLo[0])
        || ((size == SIZE_WORD) && (addrLo != 2'b00));
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the low byte/halfword/word of `data` into
// the little-endian word `rdWord` at the lane selected by `addrLo`.
//   rdWord  in  32  word read back from memory
//   data    in  32  register data (low 8/16/32 bits used)
//   size    in  2   SIZE_* code
//   addrLo  in  2   byte offset within the word
//   merged  out 32  word to write back
// An illegal size returns rdWord unchanged.
module store_lane_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] rdWord,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdWord;
    case (size)
      SIZE_WORD: merged = data;
      SIZE_HALF: merged[{addrLo[1], 4'b0000} +: 16] = data[15:0];
      SIZE_BYTE: merged[{addrLo, 3'b000} +: 8] = data[7:0];
      default:   merged = rdWord;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Multi-cycle sub-word store unit. Word stores write directly; byte and
// halfword stores read the target word, merge the new lane and write back.
//   CLK, Reset(active-low async)
//   Start, SizeSel, Addr, DataIn        request side, sampled in IDLE only
//   Busy, Done, AlignErr, TimeoutErr    status; Done/errors are 1-cycle pulses
//   MemAddr, MemRdEn, MemRdData, MemRdValid, MemWrEn, MemWrData   memory port
// RD_TIMEOUT: wait cycles without MemRdValid before giving up (0 = never).
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int RD_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  SizeSel,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr,
  output logic        TimeoutErr,
  output logic [31:0] MemAddr,
  output logic        MemRdEn,
  input  logic [31:0] MemRdData,
  input  logic        MemRdValid,
  output logic        MemWrEn,
  output logic [31:0] MemWrData
);

  localparam int CntW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

  state_t state, stateNext;
  logic [31:0] addrQ, dataQ, rdWordQ;
  logic [1:0]  sizeQ;
  logic [CntW-1:0] toCnt;
  logic toErrQ;
  logic timeoutHit;

  // True on the RD_WAIT cycle that would bring the miss count up to the limit.
  assign timeoutHit = (RD_TIMEOUT != 0) && ((toCnt + CntW'(1)) == CntW'(RD_TIMEOUT));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      addrQ   <= '0;
      dataQ   <= '0;
      sizeQ   <= '0;
      rdWordQ <= '0;
      toCnt   <= '0;
      toErrQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      toErrQ <= (state == RD_WAIT) && !MemRdValid && timeoutHit;
      if ((state == IDLE) && Start) begin
        addrQ <= Addr;
        dataQ <= DataIn;
        sizeQ <= SizeSel;
      end
      if (((state == RD_REQ) || (state == RD_WAIT)) && MemRdValid)
        rdWordQ <= MemRdData;
      if (state == RD_REQ)
        toCnt <= '0;
      else if ((state == RD_WAIT) && !MemRdValid)
        toCnt <= toCnt + CntW'(1);
    end
  end

  // The IDLE decision uses the live inputs, which are exactly what gets
  // latched on this edge, so the first active state follows Start directly.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (isIllegal(SizeSel, Addr[1:0])) stateNext = ERR;
          else if (SizeSel == SIZE_WORD)     stateNext = WR;
          else                               stateNext = RD_REQ;
        end
      end
      RD_REQ:  stateNext = MemRdValid ? WR : RD_WAIT;
      RD_WAIT: begin
        if (MemRdValid)      stateNext = WR;
        else if (timeoutHit) stateNext = DONE;
      end
      WR:      stateNext = DONE;
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  store_lane_merge uMerge (
    .rdWord (rdWordQ),
    .data   (dataQ),
    .size   (sizeQ),
    .addrLo (addrQ[1:0]),
    .merged (MemWrData)
  );

  assign Busy       = (state != IDLE);
  assign Done       = (state == DONE) || (state == ERR);
  assign AlignErr   = (state == ERR);
  assign TimeoutErr = (state == DONE) && toErrQ;
  assign MemRdEn    = (state == RD_REQ);
  assign MemWrEn    = (state == WR);
  assign MemAddr    = {addrQ[31:2], 2'b00};

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed cases plus random
// stores, checked against a byte-array memory model and cycle timing rules.
module tb_store_narrow_unit;

  localparam int RdTimeout = 15;

  logic        CLK, Reset, Start, MemRdValid;
  logic [1:0]  SizeSel;
  logic [31:0] Addr, DataIn, MemRdData;
  logic        Busy, Done, AlignErr, TimeoutErr, MemRdEn, MemWrEn;
  logic [31:0] MemAddr, MemWrData;

  int nAssert = 0;
  int nFail   = 0;

  logic [31:0] memWords [64];
  logic [7:0]  refBytes [256];

  store_narrow_unit #(.RD_TIMEOUT(RdTimeout)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .SizeSel(SizeSel), .Addr(Addr),
    .DataIn(DataIn), .Busy(Busy), .Done(Done), .AlignErr(AlignErr),
    .TimeoutErr(TimeoutErr), .MemAddr(MemAddr), .MemRdEn(MemRdEn),
    .MemRdData(MemRdData), .MemRdValid(MemRdValid), .MemWrEn(MemWrEn),
    .MemWrData(MemWrData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setWord(input int w, input logic [31:0] v);
    memWords[w] = v;
    for (int i = 0; i < 4; i++) refBytes[4*w+i] = v[8*i +: 8];
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, ".Busy"}, 32'(Busy), 32'd0);
    check({tag, ".Done"}, 32'(Done), 32'd0);
    check({tag, ".AlignErr"}, 32'(AlignErr), 32'd0);
    check({tag, ".TimeoutErr"}, 32'(TimeoutErr), 32'd0);
    check({tag, ".MemRdEn"}, 32'(MemRdEn), 32'd0);
    check({tag, ".MemWrEn"}, 32'(MemWrEn), 32'd0);
    check({tag, ".MemAddr"}, MemAddr, 32'd0);
    check({tag, ".MemWrData"}, MemWrData, 32'd0);
  endtask

  // One store; `lat` = cycles from the read request to MemRdValid.
  // Cycle numbers below are relative to the Start cycle T.
  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input int lat, output logic [31:0] wdSeen);
    int rdCyc, wrCyc, doneCyc, wrCount, rdCount, nBytes, expRd, expWr, expDone;
    logic alignSeen, toSeen, expErr, expTo;
    logic [31:0] expWord;
    int base;
    rdCyc = -1; wrCyc = -1; doneCyc = -1; wrCount = 0; rdCount = 0;
    alignSeen = 1'b0; toSeen = 1'b0; wdSeen = '0;

    @(negedge CLK);
    Addr = a; DataIn = d; SizeSel = sz; Start = 1'b1; MemRdValid = 1'b0;
    for (int c = 1; c <= 60 && doneCyc < 0; c++) begin
      @(negedge CLK);
      Addr = $urandom; DataIn = $urandom; SizeSel = 2'($urandom); Start = 1'($urandom);
      if (MemRdEn) begin
        rdCount++;
        if (rdCyc < 0) rdCyc = c;
      end
      MemRdValid = (rdCyc >= 0) && (c == rdCyc + lat);
      MemRdData  = MemRdValid ? memWords[MemAddr[7:2]] : $urandom;
      if (MemWrEn) begin
        wrCount++;
        if (wrCyc < 0) wrCyc = c;
        wdSeen = MemWrData;
        memWords[MemAddr[7:2]] = MemWrData;
      end
      if (Busy) check("MemAddr", MemAddr, {a[31:2], 2'b00});
      if (Done) begin
        doneCyc = c; alignSeen = AlignErr; toSeen = TimeoutErr;
      end
    end

    // Reference: size/alignment rules and timing, independent of the FSM.
    nBytes = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    expErr = (sz == 2'b11) || (a[1:0] % nBytes != 0);
    expTo  = 1'b0; expRd = -1; expWr = -1;
    if (expErr) expDone = 1;
    else if (sz == 2'b00) begin expWr = 1; expDone = 2; end
    else begin
      expRd = 1;
      if (RdTimeout != 0 && lat > RdTimeout) begin expTo = 1'b1; expDone = 2 + RdTimeout; end
      else begin expWr = 2 + lat; expDone = 3 + lat; end
    end

    check("doneCycle", 32'(doneCyc), 32'(expDone));
    check("rdCycle", 32'(rdCyc), 32'(expRd));
    check("rdCount", 32'(rdCount), (expRd > 0) ? 32'd1 : 32'd0);
    check("wrCycle", 32'(wrCyc), 32'(expWr));
    check("wrCount", 32'(wrCount), (expWr > 0) ? 32'd1 : 32'd0);
    check("AlignErr", 32'(alignSeen), 32'(expErr));
    check("TimeoutErr", 32'(toSeen), 32'(expTo));
    if (expWr > 0) begin
      base = int'(a[7:0]);
      for (int i = 0; i < nBytes; i++) refBytes[base+i] = d[8*i +: 8];
      base = int'(a[7:2]) * 4;
      expWord = {refBytes[base+3], refBytes[base+2], refBytes[base+1], refBytes[base]};
      check("MemWrData", wdSeen, expWord);
    end

    @(negedge CLK);
    check("idleAfter.Busy", 32'(Busy), 32'd0);
    check("idleAfter.Done", 32'(Done), 32'd0);
    Start = 1'b0; MemRdValid = 1'b0;
  endtask

  logic [31:0] wd, ra, rd;
  logic [1:0]  rs;
  int rl, sawWr;

  initial begin
    Reset = 1'b1; Start = 1'b0; SizeSel = '0; Addr = '0; DataIn = '0;
    MemRdData = '0; MemRdValid = 1'b0;
    for (int w = 0; w < 64; w++) setWord(w, $urandom);
    #1 Reset = 1'b0;
    #2 checkQuiet("reset");
    @(negedge CLK); Reset = 1'b1;

    doStore(32'h10, 32'hDEADBEEF, 2'b00, 0, wd);
    check("t1.data", wd, 32'hDEADBEEF);

    setWord(8, 32'h11223344);
    doStore(32'h23, 32'h123456AB, 2'b10, 0, wd);
    check("t2.data", wd, 32'hAB223344);

    setWord(8, 32'h11223344);
    doStore(32'h22, 32'hFFFF8096, 2'b01, 0, wd);
    check("t3.data", wd, 32'h80963344);
    setWord(8, 32'h11223344);
    doStore(32'h22, 32'hFFFF8096, 2'b01, 3, wd);
    check("t3w.data", wd, 32'h80963344);

    doStore(32'h21, 32'h0, 2'b01, 0, wd);
    doStore(32'h22, 32'h0, 2'b00, 0, wd);
    doStore(32'h20, 32'h0, 2'b11, 0, wd);

    doStore(32'h31, 32'h55, 2'b10, 100, wd);
    doStore(32'h46, 32'hA5A5, 2'b01, RdTimeout, wd);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rd = $urandom; rs = 2'($urandom);
      rl = $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) rl = $urandom_range(RdTimeout - 1, RdTimeout + 2);
      doStore(ra, rd, rs, rl, wd);
    end

    // Reset in RD_WAIT aborts the store without a later write.
    @(negedge CLK);
    Addr = 32'h55; DataIn = 32'h77; SizeSel = 2'b10; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1 checkQuiet("midReset");
    @(negedge CLK); Reset = 1'b1;
    sawWr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      MemRdValid = (c == 1);
      if (MemWrEn || Busy) sawWr = 1;
    end
    MemRdValid = 1'b0;
    check("postReset.activity", 32'(sawWr), 32'd0);
    doStore(32'h40, 32'hCAFEF00D, 2'b00, 0, wd);
    check("postReset.data", wd, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
